// File: rtl/fft_pkg.sv
// Shared types for the 4-point FFT datapath: component width, frame size,
// complex sample/frame types and the loader's collect-side states.
package fft_pkg;
  localparam int FFT_W = 16;
  localparam int FFT_N = 4;

  typedef struct packed {
    logic signed [FFT_W-1:0] re;
    logic signed [FFT_W-1:0] im;
  } cplx_t;

  typedef cplx_t [FFT_N-1:0] frame_t;

  // FILL: collect buffer accepting samples; HOLD: complete frame waiting for the output register
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } coll_state_t;
endpackage

// File: rtl/frame_reg.sv
// Four-slot complex sample register with a per-slot load enable; used both as
// the collect buffer (one slot per sample) and as the output register (all slots).
module frame_reg
  import fft_pkg::*;
#(
  parameter int W = FFT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FFT_N-1:0]          load,
  input  logic [FFT_N-1:0][W-1:0]   d_re,
  input  logic [FFT_N-1:0][W-1:0]   d_im,
  output logic [FFT_N-1:0][W-1:0]   q_re,
  output logic [FFT_N-1:0][W-1:0]   q_im
);

  genvar gi;
  generate
    for (gi = 0; gi < FFT_N; gi++) begin : g_slot
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_re[gi] <= '0;
          q_im[gi] <= '0;
        end else if (load[gi]) begin
          q_re[gi] <= d_re[gi];
          q_im[gi] <= d_im[gi];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fft4_frame_loader.sv
// Serial-to-parallel front end for the 4-point FFT: gathers samples into a
// collect buffer and hands complete frames to a double-buffered output register.
module fft4_frame_loader
  import fft_pkg::*;
#(
  parameter int W = FFT_W,
  parameter int N = FFT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_sof,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x0_re,
  output logic [W-1:0] x0_im,
  output logic [W-1:0] x1_re,
  output logic [W-1:0] x1_im,
  output logic [W-1:0] x2_re,
  output logic [W-1:0] x2_im,
  output logic [W-1:0] x3_re,
  output logic [W-1:0] x3_im,
  output logic         sync_err,
  output logic [15:0]  frame_cnt
);

  generate
    if (N != 4) begin : g_n_check
      $error("fft4_frame_loader supports N == 4 only");
    end
  endgenerate

  coll_state_t state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic        out_valid_reg, out_valid_next;
  logic        sync_err_reg, sync_err_next;
  logic [15:0] frame_cnt_reg, frame_cnt_next;

  logic        in_acc, out_acc, resync, complete, out_free;
  logic        load_direct, load_held, out_load;
  logic [1:0]  wr_idx;

  logic [FFT_N-1:0]          coll_load;
  logic [FFT_N-1:0][W-1:0]   coll_q_re, coll_q_im;
  logic [FFT_N-1:0][W-1:0]   out_d_re, out_d_im;
  logic [FFT_N-1:0][W-1:0]   out_q_re, out_q_im;

  assign in_ready  = (state_reg == FILL);
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid_reg && out_ready;
  assign resync    = in_acc && in_sof && (idx_reg != 2'd0);
  assign wr_idx    = resync ? 2'd0 : idx_reg;
  assign complete  = in_acc && !resync && (idx_reg == 2'd3);
  assign out_free  = !out_valid_reg || out_ready;
  // The last sample bypasses the collect buffer so the frame is visible one cycle after it
  assign load_direct = complete && out_free;
  assign load_held   = (state_reg == HOLD) && out_ready;
  assign out_load    = load_direct || load_held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= FILL;
      idx_reg       <= 2'd0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
      frame_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      out_valid_reg <= out_valid_next;
      sync_err_reg  <= sync_err_next;
      frame_cnt_reg <= frame_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    out_valid_next = out_valid_reg;
    sync_err_next  = resync;
    frame_cnt_next = frame_cnt_reg;

    if (in_acc) idx_next = resync ? 2'd1 : idx_reg + 2'd1;

    case (state_reg)
      FILL:    if (complete && !out_free) state_next = HOLD;
      HOLD:    if (load_held) state_next = FILL;
      default: state_next = FILL;
    endcase

    if (out_load)     out_valid_next = 1'b1;
    else if (out_acc) out_valid_next = 1'b0;

    if (out_acc) frame_cnt_next = frame_cnt_reg + 16'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < FFT_N; gi++) begin : g_path
      assign coll_load[gi] = in_acc && (wr_idx == 2'(gi));
      if (gi == FFT_N - 1) begin : g_bypass
        assign out_d_re[gi] = load_direct ? in_re : coll_q_re[gi];
        assign out_d_im[gi] = load_direct ? in_im : coll_q_im[gi];
      end else begin : g_direct
        assign out_d_re[gi] = coll_q_re[gi];
        assign out_d_im[gi] = coll_q_im[gi];
      end
    end
  endgenerate

  frame_reg #(.W(W)) u_coll (
    .clk  (clk),
    .rst  (rst),
    .load (coll_load),
    .d_re ({FFT_N{in_re}}),
    .d_im ({FFT_N{in_im}}),
    .q_re (coll_q_re),
    .q_im (coll_q_im)
  );

  frame_reg #(.W(W)) u_out (
    .clk  (clk),
    .rst  (rst),
    .load ({FFT_N{out_load}}),
    .d_re (out_d_re),
    .d_im (out_d_im),
    .q_re (out_q_re),
    .q_im (out_q_im)
  );

  assign out_valid = out_valid_reg;
  assign sync_err  = sync_err_reg;
  assign frame_cnt = frame_cnt_reg;

  assign x0_re = out_q_re[0];
  assign x0_im = out_q_im[0];
  assign x1_re = out_q_re[1];
  assign x1_im = out_q_im[1];
  assign x2_re = out_q_re[2];
  assign x2_im = out_q_im[2];
  assign x3_re = out_q_re[3];
  assign x3_im = out_q_im[3];

endmodule

// File: tb/tb_fft4_frame_loader.sv
// Directed self-checking bench for fft4_frame_loader: one task per scenario,
// inline comparisons against hand-computed values.
module tb_fft4_frame_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sof = 1'b0;
  logic [15:0] in_re = '0;
  logic [15:0] in_im = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im;
  logic        sync_err;
  logic [15:0] frame_cnt;

  int vectors = 0;
  int miscompares = 0;
  int handoffs = 0;
  int ready_drops = 0;
  int sync_pulses = 0;
  logic mon_en = 1'b0;
  logic [15:0] cap_x0 [$];

  always #5 clk = ~clk;

  fft4_frame_loader #(.W(16), .N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0_re(x0_re), .x0_im(x0_im), .x1_re(x1_re), .x1_im(x1_im),
    .x2_re(x2_re), .x2_im(x2_im), .x3_re(x3_re), .x3_im(x3_im),
    .sync_err(sync_err), .frame_cnt(frame_cnt)
  );

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      handoffs++;
      cap_x0.push_back(x0_re);
    end
  end

  always @(negedge clk) begin
    if (mon_en && !in_ready) ready_drops++;
    if (mon_en && sync_err) sync_pulses++;
  end

  // Present one sample and hold it until accepted; returns 1 time unit after the accepting edge
  task automatic push(input logic [15:0] re, input logic [15:0] im, input logic sof);
    int guard;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_sof   = sof;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready=%0b, required 1 within 50 cycles", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b, required 1", in_ready); end
    vectors++;
    if (frame_cnt !== 16'd0 || sync_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_cnt_err: frame_cnt=%0d sync_err=%0b, required 0/0", frame_cnt, sync_err);
    end
    vectors++;
    if ({x0_re, x1_im, x3_re, x3_im} !== 64'd0) begin
      miscompares++; $display("FAIL reset_data: x0_re=%h x3_im=%h, required 0", x0_re, x3_im);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(16'd1, 16'd0, 1'b1);
    push(16'd2, 16'd0, 1'b0);
    push(16'd3, 16'd0, 1'b0);
    push(16'd4, 16'd0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_latency: out_valid=%0b, required 1", out_valid); end
    vectors++;
    if ({x0_re, x1_re, x2_re, x3_re} !== {16'd1, 16'd2, 16'd3, 16'd4}) begin
      miscompares++; $display("FAIL basic_re: got %0d %0d %0d %0d, required 1 2 3 4", x0_re, x1_re, x2_re, x3_re);
    end
    vectors++;
    if ({x0_im, x1_im, x2_im, x3_im} !== 64'd0) begin
      miscompares++; $display("FAIL basic_im: got %h %h %h %h, required 0", x0_im, x1_im, x2_im, x3_im);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (frame_cnt !== 16'd1 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_handoff: frame_cnt=%0d out_valid=%0b, required 1/0", frame_cnt, out_valid);
    end
    $display("test_basic done: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) push(16'(k), 16'(k + 100), (k == 1));
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_hold: in_ready=%0b out_valid=%0b, required 0/1", in_ready, out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({x0_re, x3_re, x3_im} !== {16'd1, 16'd4, 16'd104}) begin
      miscompares++; $display("FAIL bp_frame_a_stable: x0_re=%0d x3_re=%0d x3_im=%0d, required 1 4 104", x0_re, x3_re, x3_im);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    vectors++;
    if ({x0_re, x1_re, x2_re, x3_re, x0_im} !== {16'd5, 16'd6, 16'd7, 16'd8, 16'd105}) begin
      miscompares++; $display("FAIL bp_frame_b: got %0d %0d %0d %0d im0=%0d, required 5 6 7 8 105", x0_re, x1_re, x2_re, x3_re, x0_im);
    end
    vectors++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1 || frame_cnt !== 16'd2) begin
      miscompares++; $display("FAIL bp_release: out_valid=%0b in_ready=%0b frame_cnt=%0d, required 1/1/2", out_valid, in_ready, frame_cnt);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || frame_cnt !== 16'd3) begin
      miscompares++; $display("FAIL bp_drain: out_valid=%0b frame_cnt=%0d, required 0/3", out_valid, frame_cnt);
    end
    $display("test_back_pressure done: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_resync();
    out_ready = 1'b1;
    sync_pulses = 0;
    mon_en = 1'b1;
    push(16'd10, 16'd0, 1'b1);
    push(16'd11, 16'd0, 1'b0);
    push(16'd20, 16'd0, 1'b1);
    vectors++;
    if (sync_err !== 1'b1) begin miscompares++; $display("FAIL resync_pulse: sync_err=%0b, required 1", sync_err); end
    push(16'd21, 16'd0, 1'b0);
    vectors++;
    if (sync_err !== 1'b0) begin miscompares++; $display("FAIL resync_pulse_width: sync_err=%0b, required 0", sync_err); end
    push(16'd22, 16'd0, 1'b0);
    push(16'd23, 16'd0, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || {x0_re, x1_re, x2_re, x3_re} !== {16'd20, 16'd21, 16'd22, 16'd23}) begin
      miscompares++; $display("FAIL resync_frame: valid=%0b got %0d %0d %0d %0d, required 1: 20 21 22 23", out_valid, x0_re, x1_re, x2_re, x3_re);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    vectors++;
    if (sync_pulses !== 1) begin miscompares++; $display("FAIL resync_count: pulses=%0d, required 1", sync_pulses); end
    $display("test_resync done: sync_pulses=%0d", sync_pulses);
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    handoffs = 0;
    ready_drops = 0;
    cap_x0.delete();
    mon_en = 1'b1;
    for (int k = 1; k <= 16; k++) push(16'(k), 16'd0, (k == 1));
    vectors++;
    if (out_valid !== 1'b1 || {x0_re, x3_re} !== {16'd13, 16'd16}) begin
      miscompares++; $display("FAIL stream_last_frame: valid=%0b x0_re=%0d x3_re=%0d, required 1: 13 16", out_valid, x0_re, x3_re);
    end
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    vectors++;
    if (frame_cnt !== 16'd4 || handoffs !== 4) begin
      miscompares++; $display("FAIL stream_count: frame_cnt=%0d handoffs=%0d, required 4/4", frame_cnt, handoffs);
    end
    vectors++;
    if (ready_drops !== 0) begin miscompares++; $display("FAIL stream_in_ready: low cycles=%0d, required 0", ready_drops); end
    vectors++;
    if (cap_x0.size() != 4 || cap_x0[1] !== 16'd5 || cap_x0[2] !== 16'd9) begin
      miscompares++; $display("FAIL stream_order: frames=%0d, required 4 frames with x0 = 1 5 9 13", cap_x0.size());
    end
    $display("test_streaming done: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) push(16'(30 + k), 16'd0, (k == 1));
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("FAIL rmid_setup: out_valid=%0b, required 1", out_valid); end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || sync_err !== 1'b0) begin
      miscompares++; $display("FAIL rmid_async: out_valid=%0b sync_err=%0b, required 0/0", out_valid, sync_err);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (frame_cnt !== 16'd0 || in_ready !== 1'b1 || x0_re !== 16'd0) begin
      miscompares++; $display("FAIL rmid_release: frame_cnt=%0d in_ready=%0b x0_re=%0d, required 0/1/0", frame_cnt, in_ready, x0_re);
    end
    for (int k = 0; k < 4; k++) push(16'(50 + k), 16'(60 + k), 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || {x0_re, x1_re, x2_re, x3_re, x3_im} !== {16'd50, 16'd51, 16'd52, 16'd53, 16'd63}) begin
      miscompares++; $display("FAIL rmid_clean_frame: got %0d %0d %0d %0d im3=%0d, required 50 51 52 53 63", x0_re, x1_re, x2_re, x3_re, x3_im);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    $display("test_reset_mid done: frame_cnt=%0d", frame_cnt);
  endtask

  task automatic test_extremes();
    out_ready = 1'b0;
    push(16'h8000, 16'h7FFF, 1'b1);
    push(16'h7FFF, 16'h8000, 1'b0);
    push(16'h8000, 16'h8000, 1'b0);
    push(16'h7FFF, 16'h7FFF, 1'b0);
    vectors++;
    if ({x0_re, x1_re, x2_re, x3_re} !== {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}) begin
      miscompares++; $display("FAIL ext_re: got %h %h %h %h, required 8000 7fff 8000 7fff", x0_re, x1_re, x2_re, x3_re);
    end
    vectors++;
    if ({x0_im, x1_im, x2_im, x3_im} !== {16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF}) begin
      miscompares++; $display("FAIL ext_im: got %h %h %h %h, required 7fff 8000 8000 7fff", x0_im, x1_im, x2_im, x3_im);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || frame_cnt !== 16'd2) begin
      miscompares++; $display("FAIL ext_drain: out_valid=%0b frame_cnt=%0d, required 0/2", out_valid, frame_cnt);
    end
    $display("test_extremes done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_resync();
    test_streaming();
    test_reset_mid();
    test_extremes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft4_frame_loader.md
Name: fft4_frame_loader

Overview:
- Serial-to-parallel front end for the 4-point radix-2 DIT FFT core.
- Accepts one complex sample per handshake and assembles 4-sample frames in natural order x0..x3.
- Presents each complete frame as eight parallel words with a valid/ready handshake.
- Double-buffered (collect buffer plus output register), so streaming continues while the FFT consumer holds a frame.

Parameters:
- W, 16, width of each real/imag component (two's complement).
- N, 4, samples per frame. Fixed at 4; a value other than 4 is a compile-time error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  loader can accept a sample this cycle.
- in_sof  in  1  start of frame; qualifies the sample as x0 of a new frame.
- in_re  in  W  sample real part.
- in_im  in  W  sample imaginary part.
- out_valid  out  1  complete frame held on x*_re/x*_im.
- out_ready  in  1  consumer accepts the frame.
- x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im  out  W each  frame samples, index = arrival order.
- sync_err  out  1  one-cycle pulse when a partial frame is discarded.
- frame_cnt  out  16  count of frames handed off (out_valid && out_ready); wraps at 2^16.

Behaviour:
- Reset (async assert, sync release):
  - idx=0, coll_full=0, out_valid=0, all x*=0, sync_err=0, frame_cnt=0.
  - in_ready is 1 after reset.
- Transfers:
  - Input accept: in_valid && in_ready.
  - Output accept: out_valid && out_ready.
- in_ready = !coll_full (combinational from registered state only; no path from in_valid or out_ready).
- Collect state machine, tracked by 2-bit idx and coll_full:
  - FILL (idx 0..3): an accepted sample writes slot idx. Then idx increments, or wraps to 0 after slot 3.
  - Slot 3 accepted:
    - Output register empty, or draining in the same cycle: the frame moves to the output register at that edge; out_valid=1 next cycle. Latency from the 4th accept to out_valid is 1 cycle.
    - Otherwise: coll_full=1 (state HOLD) and in_ready=0.
  - HOLD: on output accept, the collect buffer moves to the output register at the same edge. Then coll_full=0 and out_valid stays 1.
- Output register:
  - out_valid clears on output accept only if no new frame loads at that edge.
  - Data is stable while out_valid && !out_ready.
- Sync (applies only to accepted samples):
  - in_sof with idx!=0: discard the partial frame. The sample is written to slot 0, idx becomes 1, and sync_err pulses high for 1 cycle (the cycle after the accept).
  - in_sof with idx=0: normal.
  - No in_sof at idx=0: accepted as x0 (free-running framing).
- in_valid && !in_ready: sample ignored, no state change. The upstream source must hold its data.
- frame_cnt increments on each output accept.
- Reset mid-frame: the partial frame and any held frame are dropped with no sync_err. out_valid drops asynchronously.
- Pure data movement: no arithmetic, no width change.

Decomposition:
- Shared package fft_pkg:
  - localparam FFT_W=16, FFT_N=4.
  - typedef cplx_t: packed struct {logic signed [FFT_W-1:0] re, im;}.
  - typedef frame_t: cplx_t [FFT_N-1:0].
- Sub-module frame_reg: a W-parameterised 4-slot complex register with load enable. Instantiated twice, as the collect buffer and the output register.
- Control (idx, coll_full, out_valid, sync_err, frame_cnt) stays in the top module.

Test Plan:
- Basic frame: reset, out_ready=1; send (1,0),(2,0),(3,0),(4,0) with in_sof on the first. Expect out_valid 1 cycle after the 4th accept, x0_re..x3_re = 1,2,3,4, all imag 0, frame_cnt=1.
- Back-pressure: out_ready=0; send 8 samples continuously. Expect in_ready=0 after the 8th accept and frame A (samples 1-4) stable. Raise out_ready for 1 cycle: frame B (5-8) appears the next cycle, in_ready=1, and no samples are lost.
- Resync: send samples 10,11 then 20 with in_sof, then 21,22,23. Expect a sync_err pulse once and an output frame of 20,21,22,23.
- Streaming: out_ready=1, in_valid=1 continuously for 16 samples. Expect in_ready held at 1, 4 frames with out_valid high, and frame_cnt=4.
- Reset mid-operation: assert rst after 2 samples and with a held frame. Expect out_valid=0 immediately, frame_cnt=0 and in_ready=1 after release. The next 4 samples form a clean frame.
- Sign/extremes: samples 16'h8000 / 16'h7FFF in re/im. Expect bit-exact pass-through on the matching x* ports.
